mdu_sequencer: RTL and testbench



---
 rtl/mdu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mdu_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide
// step per cycle, with divide-by-zero and signed-overflow results short-circuited.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [2:0]         op;
    logic               neg;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opb;
    // Multiplier sits in the low half and shifts out as the product shifts in.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;

    logic               a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic               div_zero, div_ovf, fast, accept;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_res;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (Funct3)
            3'b001, 3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010:  a_sgn = 1'b1;
            default: ;
        endcase
        a_neg    = a_sgn & SrcA[WIDTH-1];
        b_neg    = b_sgn & SrcB[WIDTH-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        // REM takes the dividend's sign; every other op uses the sign XOR.
        neg_in   = (Funct3[2] && Funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_res = Funct3[1] ? SrcA : '1;
        else
            fast_res = Funct3[1] ? '0 : SrcA;
        accept   = (state == IDLE) && start && !flush;
    end

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_sh, div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        addend    = prod[0] ? opb : '0;
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_sh    = {rem, quo[WIDTH-1]};
        div_trial = div_sh - {2'b00, opb};
        prod_fix  = neg ? -prod : prod;
        quo_fix   = neg ? -quo : quo;
        rem_fix   = neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        case (op)
            3'b000:                 fix_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = fast ? DONE : CALC;
            CALC: begin
                if (flush)
                    state_nx = IDLE;
                else if (cnt == '0)
                    state_nx = FIX;
            end
            FIX:     state_nx = flush ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            opb    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op   <= Funct3;
                        neg  <= neg_in;
                        cnt  <= CW'(WIDTH - 1);
                        opb  <= b_mag;
                        prod <= {{WIDTH{1'b0}}, a_mag};
                        rem  <= '0;
                        quo  <= a_mag;
                        if (fast)
                            Result <= fast_res;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        if (op[2]) begin
                            quo <= {quo[WIDTH-2:0], ~div_trial[WIDTH+1]};
                            rem <= div_trial[WIDTH+1] ? div_sh[WIDTH:0] : div_trial[WIDTH:0];
                        end else begin
                            prod <= {mul_sum, prod[WIDTH-1:1]};
                        end
                        if (cnt != '0)
                            cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    if (!flush)
                        Result <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, hand-written
// flush/reset/DONE-start sequences, and random ops against an arithmetic model.
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   Funct3 = '0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         busy, done;
    logic [W-1:0] Result;

    int n_total = 0;
    int n_pass  = 0;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference result from plain 64-bit arithmetic on the RV32M definitions.
    function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0:    return 32'(ua * ub);
            3'd1:    return 32'((sa * sb) >>> 32);
            3'd2:    return 32'((sa * longint'(ub)) >>> 32);
            3'd3:    return 32'((ua * ub) >> 32);
            3'd4:    return (b == 0) ? '1 : 32'(sa / sb);
            3'd5:    return (b == 0) ? '1 : a / b;
            3'd6:    return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
        return W + 1;
    endfunction

    // lat = edges after the accept edge until done is seen.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int lat, input string name);
        int j;
        int busy_err;
        @(negedge clk);
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        j = 0;
        busy_err = 0;
        while (!done && j < 60) begin
            if (busy !== (j < lat)) busy_err++;
            @(posedge clk);
            #1 j++;
        end
        if (busy !== 1'b0) busy_err++;
        check({name, " result"}, Result, exp_res);
        check({name, " latency"}, j, lat);
        check({name, " busy"}, busy_err, 0);
        @(posedge clk);
        #1 check({name, " done pulse"}, done, 1'b0);
    endtask

    vec_t vecs[12];

    initial begin
        int seen;
        logic [2:0]   rf;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         0};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};

        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset result", Result, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));

        // Mid-CALC start is ignored, flush sampled at iteration 10 aborts.
        run_op(3'd0, 32'h1234, 32'd1, 32'h1234, 33, "setup");
        @(negedge clk);
        Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("restart ignored busy", busy, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush idle", {busy, done}, 2'b00);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done || busy) seen++;
        end
        check("flush no done", seen, 0);
        check("flush result held", Result, 32'h1234);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "after flush");

        // Flush beats start in IDLE.
        @(negedge clk);
        Funct3 = 3'd4; SrcA = 32'd5; SrcB = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("idle flush priority", {busy, done}, 2'b00);
        check("idle flush result", Result, 32'd12);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async reset flags", {busy, done}, 2'b00);
        check("async reset result", Result, '0);
        @(negedge clk) reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        check("no done after reset", seen, 0);

        // start held through the DONE cycle must not launch another op.
        @(negedge clk);
        Funct3 = 3'd4; SrcA = 32'd5; SrcB = 32'd0; start = 1'b1;
        @(posedge clk);
        #1 check("done-start fast done", done, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        check("done-start ignored", {busy, done}, 2'b00);
        @(posedge clk);
        #1 check("done-start still idle", {busy, done}, 2'b00);

        for (int i = 0; i < 120; i++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ra = '0;
                1:       ra = 32'h8000_0000;
                2:       ra = '1;
                3:       ra = 32'($urandom_range(0, 3));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 32'h8000_0000;
                2:       rb = '1;
                3:       rb = 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            run_op(rf, ra, rb, ref_op(rf, ra, rb), ref_lat(rf, ra, rb),
                   $sformatf("rnd%0d f%0d %h %h", i, rf, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
